// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Optional feature macro: FETCH_ADDR_CHECK_EN (enables fetch address error detection).
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        exp_flag;
        logic [4:0]  exc_code;
        logic        bd;
    } ifid_t;

    // Update command for the IF/ID register
    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_LOAD  = 2'd1,
        IFID_CLEAR = 2'd2
    } ifid_ctl_e;

    // A fetch address is bad when misaligned or outside instruction memory
    function automatic logic addr_bad(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with load / hold / clear control.
// A clear loads a bubble (nop, no flags) whose PC is supplied by the caller.
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  ifid_ctl_e   ctl,
    input  logic [31:0] clear_pc,
    input  ifid_t       fetch,
    output ifid_t       q
);

    // Register update: reset wins, then clear, load or hold
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '{ins: NOP, pc: PC_RESET, exp_flag: 1'b0, exc_code: 5'd0, bd: 1'b0};
        end else begin
            case (ctl)
                IFID_CLEAR: q <= '{ins: NOP, pc: clear_pc, exp_flag: 1'b0, exc_code: 5'd0, bd: 1'b0};
                IFID_LOAD:  q <= fetch;
                default:    q <= q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, fetch address
// check and the IF/ID register feeding decode.
// Optional feature macro: FETCH_ADDR_CHECK_EN -- when defined, a fetch from a
// misaligned or out-of-range PC is replaced by a nop tagged with AdEL.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic        Branch,
    input  logic [31:0] PCbranch,
    input  logic        isj,
    input  logic [31:0] PCjump,
    input  logic        jr,
    input  logic [31:0] PCjr,
    input  logic        Branch_for_delay,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] EPC,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Ins_IFout,
    output logic [31:0] PC_IFout,
    output logic        expFlag_IFout,
    output logic [4:0]  ExcCode_IFout,
    output logic        bd_IFout
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        fetch_err;
    ifid_t       fetch;
    ifid_t       ifid_q;
    ifid_ctl_e   ifid_ctl;
    logic [31:0] ifid_clear_pc;

    // PC register; reset overrides every other request
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= PC_RESET;
        end else begin
            pc <= pc_next;
        end
    end

    // Next-PC priority: exception, eret, stall, then decode redirects.
    // A redirect under stall is dropped; decode presents it again later.
    always_comb begin
        pc_next = pc + 32'd4;
        if (req) begin
            pc_next = EXC_ENTRY;
        end else if (eret) begin
            pc_next = EPC;
        end else if (stop) begin
            pc_next = pc;
        end else if (jr) begin
            pc_next = PCjr;
        end else if (isj) begin
            pc_next = PCjump;
        end else if (Branch) begin
            pc_next = PCbranch;
        end
    end

    // A bad PC is flagged only when it is fetched, never at the redirecting instruction
    always_comb begin
`ifdef FETCH_ADDR_CHECK_EN
        fetch_err = addr_bad(pc);
`else
        fetch_err = 1'b0;
`endif
    end

    // Fetch result; taken branches do not flush, so the delay-slot word is kept
    always_comb begin
        fetch.ins      = fetch_err ? NOP : imem_rdata;
        fetch.pc       = pc;
        fetch.exp_flag = fetch_err;
        fetch.exc_code = fetch_err ? EXC_ADEL : 5'd0;
        fetch.bd       = Branch_for_delay;
    end

    // IF/ID control: exception and eret squash the slot, stall holds
    always_comb begin
        ifid_ctl      = IFID_LOAD;
        ifid_clear_pc = EXC_ENTRY;
        if (req) begin
            ifid_ctl      = IFID_CLEAR;
            ifid_clear_pc = EXC_ENTRY;
        end else if (eret) begin
            ifid_ctl      = IFID_CLEAR;
            ifid_clear_pc = EPC;
        end else if (stop) begin
            ifid_ctl      = IFID_HOLD;
        end
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .reset    (reset),
        .ctl      (ifid_ctl),
        .clear_pc (ifid_clear_pc),
        .fetch    (fetch),
        .q        (ifid_q)
    );

    assign imem_addr     = pc;
    assign Ins_IFout     = ifid_q.ins;
    assign PC_IFout      = ifid_q.pc;
    assign expFlag_IFout = ifid_q.exp_flag;
    assign ExcCode_IFout = ifid_q.exc_code;
    assign bd_IFout      = ifid_q.bd;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes the expected
// PC and IF/ID contents into a scoreboard queue as each cycle's stimulus is
// driven; they are popped and compared after the clock edge.
// Honours FETCH_ADDR_CHECK_EN the same way as the design.
module tb_fetch_stage;

`ifdef FETCH_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] ifpc;
        logic        expf;
        logic [4:0]  exc;
        logic        bd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stop, Branch, isj, jr, Branch_for_delay, req, eret;
    logic [31:0] PCbranch, PCjump, PCjr, EPC;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] Ins_IFout, PC_IFout;
    logic        expFlag_IFout, bd_IFout;
    logic [4:0]  ExcCode_IFout;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t m;            // model state after the last edge
    bit   m_valid = 1'b0;

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_stage dut (
        .clk(clk), .reset(reset), .stop(stop),
        .Branch(Branch), .PCbranch(PCbranch),
        .isj(isj), .PCjump(PCjump),
        .jr(jr), .PCjr(PCjr),
        .Branch_for_delay(Branch_for_delay),
        .req(req), .eret(eret), .EPC(EPC),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .Ins_IFout(Ins_IFout), .PC_IFout(PC_IFout),
        .expFlag_IFout(expFlag_IFout), .ExcCode_IFout(ExcCode_IFout),
        .bd_IFout(bd_IFout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the model's prediction, then compare
    task automatic step(input logic r, input logic s, input logic b, input logic j,
                        input logic jrv, input logic bfd, input logic q, input logic e,
                        input logic [31:0] pb, input logic [31:0] pj,
                        input logic [31:0] pr, input logic [31:0] ep);
        exp_t nx;
        exp_t got;
        logic err;
        @(negedge clk);
        reset = r; stop = s; Branch = b; isj = j; jr = jrv; Branch_for_delay = bfd;
        req = q; eret = e; PCbranch = pb; PCjump = pj; PCjr = pr; EPC = ep;
        if (m_valid) chk("imem_addr_pre", imem_addr, m.pc);
        err = CHECK_EN && ((m.pc[1:0] != 2'b00) || (m.pc < 32'h3000) || (m.pc > 32'h6FFC));
        nx = m;
        if (r) begin
            nx = '{pc: 32'h3000, ins: 32'h0, ifpc: 32'h3000, expf: 1'b0, exc: 5'd0, bd: 1'b0};
        end else if (q) begin
            nx = '{pc: 32'h4180, ins: 32'h0, ifpc: 32'h4180, expf: 1'b0, exc: 5'd0, bd: 1'b0};
        end else if (e) begin
            nx = '{pc: ep, ins: 32'h0, ifpc: ep, expf: 1'b0, exc: 5'd0, bd: 1'b0};
        end else if (s) begin
            nx = m;
        end else begin
            nx.pc   = jrv ? pr : j ? pj : b ? pb : m.pc + 32'd4;
            nx.ins  = err ? 32'h0 : mem(m.pc);
            nx.ifpc = m.pc;
            nx.expf = err;
            nx.exc  = err ? 5'd4 : 5'd0;
            nx.bd   = bfd;
        end
        sb_q.push_back(nx);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("imem_addr", imem_addr, got.pc);
        chk("Ins_IFout", Ins_IFout, got.ins);
        chk("PC_IFout", PC_IFout, got.ifpc);
        chk("expFlag_IFout", {31'b0, expFlag_IFout}, {31'b0, got.expf});
        chk("ExcCode_IFout", {27'b0, ExcCode_IFout}, {27'b0, got.exc});
        chk("bd_IFout", {31'b0, bd_IFout}, {31'b0, got.bd});
        m = got;
        m_valid = 1'b1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_3002;
            1:       return 32'h0000_7000;
            2:       return 32'h0000_2FFC;
            default: return 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
        endcase
    endfunction

    initial begin
        reset = 1; stop = 0; Branch = 0; isj = 0; jr = 0; Branch_for_delay = 0;
        req = 0; eret = 0; PCbranch = 0; PCjump = 0; PCjr = 0; EPC = 0;

        // Reset, with req/eret/stop asserted to check reset priority
        step(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h5000);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_addr", imem_addr, 32'h3000);
        chk("rst_ins", Ins_IFout, 32'h0);
        chk("rst_pc_if", PC_IFout, 32'h3000);

        // Straight-line fetch
        idle();
        chk("seq_addr1", imem_addr, 32'h3004);
        chk("seq_pcif1", PC_IFout, 32'h3000);
        idle();
        chk("seq_addr2", imem_addr, 32'h3008);
        chk("seq_pcif2", PC_IFout, 32'h3004);

        // Branch at 0x3008 with delay slot
        step(0, 0, 1, 0, 0, 1, 0, 0, 32'h3100, 0, 0, 0);
        chk("br_ins", Ins_IFout, mem(32'h3008));
        chk("br_bd", {31'b0, bd_IFout}, 32'd1);
        chk("br_addr", imem_addr, 32'h3100);

        // Redirect to 0x3010 (jr outranks isj and Branch), then stall 3 cycles
        step(0, 0, 1, 1, 1, 1, 0, 0, 32'h3200, 32'h3300, 32'h3010, 0);
        chk("jr_prio_addr", imem_addr, 32'h3010);
        repeat (3) step(0, 1, 1, 0, 1, 1, 0, 0, 32'h3200, 0, 32'h3400, 0);
        chk("stall_addr", imem_addr, 32'h3010);
        chk("stall_pcif", PC_IFout, 32'h3100);
        idle();
        chk("rel_addr", imem_addr, 32'h3014);
        chk("rel_pcif", PC_IFout, 32'h3010);

        // Exception together with stop and jr
        step(0, 1, 0, 0, 1, 1, 1, 1, 0, 0, 32'h3500, 32'h3600);
        chk("exc_addr", imem_addr, 32'h4180);
        chk("exc_ins", Ins_IFout, 32'h0);
        chk("exc_pcif", PC_IFout, 32'h4180);
        idle();

        // eret
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h3024);
        chk("eret_addr", imem_addr, 32'h3024);
        chk("eret_ins", Ins_IFout, 32'h0);
        idle();

        // Bad targets: flagged when fetched, not at the jr
        step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h3002, 0);
        chk("adel1_src_flag", {31'b0, expFlag_IFout}, 32'd0);
        idle();
        chk("adel1_flag", {31'b0, expFlag_IFout}, {31'b0, CHECK_EN});
        chk("adel1_code", {27'b0, ExcCode_IFout}, CHECK_EN ? 32'd4 : 32'd0);
        chk("adel1_ins", Ins_IFout, CHECK_EN ? 32'h0 : mem(32'h3002));
        chk("adel1_pcif", PC_IFout, 32'h3002);
        step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h7000, 0);
        idle();
        chk("adel2_flag", {31'b0, expFlag_IFout}, {31'b0, CHECK_EN});
        chk("adel2_code", {27'b0, ExcCode_IFout}, CHECK_EN ? 32'd4 : 32'd0);
        chk("adel2_ins", Ins_IFout, CHECK_EN ? 32'h0 : mem(32'h7000));
        chk("adel2_pcif", PC_IFout, 32'h7000);

        // Reset in the middle of a stall leaves no held state
        step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h5000, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("post_rst_pcif", PC_IFout, 32'h3000);
        chk("post_rst_ins", Ins_IFout, mem(32'h3000));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic s, b, j, jrv, q, e;
            s   = ($urandom_range(0, 3) == 0);
            b   = ($urandom_range(0, 5) == 0);
            j   = ($urandom_range(0, 7) == 0);
            jrv = ($urandom_range(0, 7) == 0);
            q   = ($urandom_range(0, 19) == 0);
            e   = ($urandom_range(0, 19) == 0);
            step(($urandom_range(0, 99) == 0), s, b, j, jrv, (b | j | jrv),
                 q, e, rand_target(), rand_target(), rand_target(), rand_target());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
